// File: rtl/bram_sp_model.sv
// Behavioural 16x16 single-port RAM responder with a post-reset clear, a read pipeline of RD_LAT edges and access statistics.
// Latency RD_LAT edges from the sampling edge to douta/douta_vld; there is no backpressure, and accesses made while busy are dropped and flagged.
module bram_sp_model #(
   parameter int          RD_LAT   = 2,
   parameter logic [15:0] INIT_VAL = 16'h0000
) (
   input  logic        rst,
   input  logic        clka,
   input  logic        ena,
   input  logic        wea,
   input  logic [3:0]  addra,
   input  logic [15:0] dina,
   output logic [15:0] douta,
   output logic        douta_vld,
   output logic        busy,
   output logic [7:0]  wr_cnt,
   output logic [7:0]  rd_cnt,
   output logic        err
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  clr_addr_q, clr_addr_d;
   logic [7:0]  wr_cnt_q, wr_cnt_d;
   logic [7:0]  rd_cnt_q, rd_cnt_d;
   logic        err_q, err_d;
   logic [15:0] douta_q, douta_d;
   logic        vld_q, vld_d;
   logic [15:0] mem_q [16];

   logic        ready;
   logic        wr_fire;
   logic        rd_fire;
   logic        out_vld;
   logic [15:0] out_dat;

   assign ready   = (state_q == ST_READY);
   assign wr_fire = ready & ena & wea;
   assign rd_fire = ready & ena & ~wea;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      err_d      = err_q;
      if (state_q == ST_CLEAR) begin
         clr_addr_d = clr_addr_q + 4'd1;
         if (clr_addr_q == 4'd15) state_d = ST_READY;
         if (ena) err_d = 1'b1;
      end
      if (wr_fire && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
      if (rd_fire && rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= 4'd0;
         wr_cnt_q   <= 8'd0;
         rd_cnt_q   <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         err_q      <= err_d;
      end
   end

   // Storage has no reset; the clear sequence is what initialises it.
   always_ff @(posedge clka) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_addr_q] <= INIT_VAL;
      end else if (wr_fire) begin
         mem_q[addra] <= dina;
      end
   end

   // The output register is the last stage; only RD_LAT-1 stages sit in front of it.
   if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("bram_sp_model: RD_LAT must be 1..3");
   end else if (RD_LAT == 1) begin : g_lat1
      assign out_vld = rd_fire;
      assign out_dat = mem_q[addra];
   end else begin : g_latn
      logic [RD_LAT-2:0] pvld_q;
      logic [15:0]       pdat_q [RD_LAT-1];

      always_ff @(posedge clka or posedge rst) begin
         if (rst) begin
            pvld_q <= '0;
         end else begin
            pvld_q[0] <= rd_fire;
            for (int i = 1; i < RD_LAT-1; i++) pvld_q[i] <= pvld_q[i-1];
         end
      end

      always_ff @(posedge clka) begin
         pdat_q[0] <= mem_q[addra];
         for (int i = 1; i < RD_LAT-1; i++) pdat_q[i] <= pdat_q[i-1];
      end

      assign out_vld = pvld_q[RD_LAT-2];
      assign out_dat = pdat_q[RD_LAT-2];
   end

   always_comb begin
      vld_d   = out_vld;
      douta_d = out_vld ? out_dat : douta_q;
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         douta_q <= 16'h0000;
         vld_q   <= 1'b0;
      end else begin
         douta_q <= douta_d;
         vld_q   <= vld_d;
      end
   end

   assign douta     = douta_q;
   assign douta_vld = vld_q;
   assign busy      = ~ready;
   assign wr_cnt    = wr_cnt_q;
   assign rd_cnt    = rd_cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bram_sp_model.sv
// Three responders (RD_LAT 1, 2, 3) share one stimulus stream; a memory-array model predicts each read's data and due edge.
module tb_bram_sp_model;

   typedef struct {
      int          due;
      logic [15:0] dat;
   } exp_t;

   localparam logic [15:0] INIT = 16'h0000;

   logic        clka;
   logic        rst;
   logic        ena;
   logic        wea;
   logic [3:0]  addra;
   logic [15:0] dina;

   logic [15:0] douta_w [3];
   logic        vld_w   [3];
   logic        busy_w  [3];
   logic [7:0]  wr_w    [3];
   logic [7:0]  rd_w    [3];
   logic        err_w   [3];

   int          lat [3];
   exp_t        q [3][$];
   logic [15:0] mem_m [16];
   int          wr_m;
   int          rd_m;
   bit          err_m;
   int          cyc;
   int          edges_r;
   int          n_chk;
   int          n_pass;

   bram_sp_model #(.RD_LAT(1), .INIT_VAL(INIT)) u_lat1 (
      .rst(rst), .clka(clka), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta_w[0]), .douta_vld(vld_w[0]), .busy(busy_w[0]),
      .wr_cnt(wr_w[0]), .rd_cnt(rd_w[0]), .err(err_w[0]));

   bram_sp_model #(.RD_LAT(2), .INIT_VAL(INIT)) u_lat2 (
      .rst(rst), .clka(clka), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta_w[1]), .douta_vld(vld_w[1]), .busy(busy_w[1]),
      .wr_cnt(wr_w[1]), .rd_cnt(rd_w[1]), .err(err_w[1]));

   bram_sp_model #(.RD_LAT(3), .INIT_VAL(INIT)) u_lat3 (
      .rst(rst), .clka(clka), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta_w[2]), .douta_vld(vld_w[2]), .busy(busy_w[2]),
      .wr_cnt(wr_w[2]), .rd_cnt(rd_w[2]), .err(err_w[2]));

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   always @(posedge clka) cyc <= cyc + 1;

   always @(posedge clka or posedge rst) begin
      if (rst) edges_r <= 0;
      else     edges_r <= edges_r + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Scoreboard monitor: every pulse must match the oldest expected read, on its due edge.
   always @(negedge clka) begin
      if (!rst) begin
         for (int p = 0; p < 3; p++) begin
            if (vld_w[p]) begin
               if (q[p].size() == 0) begin
                  chk($sformatf("lat%0d_unexpected_vld", lat[p]), 32'(vld_w[p]), 32'(q[p].size() > 0));
               end else begin
                  exp_t e;
                  e = q[p].pop_front();
                  chk($sformatf("lat%0d_read{edge,data}", lat[p]),
                      {cyc[15:0], douta_w[p]}, {e.due[15:0], e.dat});
               end
            end else if (q[p].size() > 0 && q[p][0].due <= cyc) begin
               exp_t e;
               e = q[p].pop_front();
               chk($sformatf("lat%0d_missing_vld_due%0d", lat[p], e.due), 32'(vld_w[p]), 32'd1);
            end
         end
      end
   end

   // One access presented for the next rising edge; the model decides its effect.
   task automatic access(input bit e, input bit w, input logic [3:0] a, input logic [15:0] d);
      @(posedge clka);
      #2;
      ena   = e;
      wea   = w;
      addra = a;
      dina  = d;
      if (e) begin
         if (edges_r + 1 <= 16) begin
            err_m = 1'b1;
         end else if (w) begin
            mem_m[a] = d;
            wr_m++;
         end else begin
            rd_m++;
            for (int p = 0; p < 3; p++) begin
               exp_t x;
               x.due = cyc + lat[p];
               x.dat = mem_m[a];
               q[p].push_back(x);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) access(1'b0, 1'b0, 4'd0, 16'h0000);
   endtask

   task automatic do_reset(input bit watch_busy);
      @(posedge clka);
      #2;
      ena = 1'b0;
      wea = 1'b0;
      rst = 1'b1;
      for (int p = 0; p < 3; p++) q[p].delete();
      for (int i = 0; i < 16; i++) mem_m[i] = INIT;
      wr_m  = 0;
      rd_m  = 0;
      err_m = 1'b0;
      @(negedge clka);
      for (int p = 0; p < 3; p++) begin
         chk("rst_douta", 32'(douta_w[p]), 32'(16'h0000));
         chk("rst_vld", 32'(vld_w[p]), 32'd0);
         chk("rst_busy", 32'(busy_w[p]), 32'd1);
         chk("rst_cnts_err", {15'd0, err_w[p], wr_w[p], rd_w[p]}, 32'd0);
      end
      repeat (2) @(posedge clka);
      #2;
      rst = 1'b0;
      if (watch_busy) begin
         for (int i = 0; i < 17; i++) begin
            @(negedge clka);
            chk($sformatf("busy_after_%0d_edges", edges_r), 32'(busy_w[1]), 32'(edges_r < 16));
         end
      end
   endtask

   task automatic check_stats(input string tag);
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("%s_lat%0d_wr_cnt", tag, lat[p]), 32'(wr_w[p]), 32'(sat(wr_m)));
         chk($sformatf("%s_lat%0d_rd_cnt", tag, lat[p]), 32'(rd_w[p]), 32'(sat(rd_m)));
         chk($sformatf("%s_lat%0d_err", tag, lat[p]), 32'(err_w[p]), 32'(err_m));
      end
   endtask

   initial begin
      lat[0] = 1; lat[1] = 2; lat[2] = 3;
      n_chk = 0; n_pass = 0; cyc = 0;
      rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = 4'd0; dina = 16'h0000;

      // Clear sequence, then every word reads back as INIT.
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 4'(i), 16'h0000);
      idle(5);
      check_stats("clear");

      // Controller pattern: shift-in-ones writes, back-to-back reads.
      for (int i = 0; i < 16; i++) access(1'b1, 1'b1, 4'(i), 16'((32'h1 << (i + 1)) - 1));
      for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 4'(i), 16'h0000);
      idle(5);
      check_stats("pattern");

      // Latency sweep across all three responders at once.
      access(1'b1, 1'b1, 4'd5, 16'hA5A5);
      access(1'b1, 1'b0, 4'd5, 16'h0000);
      idle(5);

      // Write attempted on the 5th edge after reset is rejected and flagged.
      do_reset(1'b0);
      idle(3);
      access(1'b1, 1'b1, 4'd3, 16'h1234);
      idle(15);
      for (int p = 0; p < 3; p++) chk("err_during_clear", 32'(err_w[p]), 32'd1);
      access(1'b1, 1'b0, 4'd3, 16'h0000);
      idle(5);
      check_stats("clear_access");

      // Randomised traffic with idles; read-after-write hazards arise naturally.
      for (int i = 0; i < 300; i++) begin
         access($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
      end
      idle(5);
      check_stats("random");

      // Reads in flight when reset hits must never complete.
      for (int i = 0; i < 3; i++) access(1'b1, 1'b0, 4'(i), 16'h0000);
      do_reset(1'b0);
      idle(20);
      check_stats("rst_mid_read");

      // Saturation of the write counter; the last write still lands.
      for (int i = 0; i < 299; i++) access(1'b1, 1'b1, 4'($urandom), 16'($urandom));
      access(1'b1, 1'b1, 4'd9, 16'hBEEF);
      access(1'b1, 1'b0, 4'd9, 16'h0000);
      idle(5);
      check_stats("saturate");
      for (int p = 0; p < 3; p++) chk("sat_wr_cnt_255", 32'(wr_w[p]), 32'd255);

      for (int p = 0; p < 3; p++) chk($sformatf("lat%0d_reads_outstanding", lat[p]), q[p].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
